// File: rtl/spi_slave_if.sv
// SPI slave endpoint: oversamples sclk/cs/mosi in the clk domain, decodes write
// frames into rx_data and serialises the transmit buffer on read frames.
module spi_slave_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  rd_done,
  output logic                  frame_err,
  output logic [1:0]            dbg_state
);

  localparam int CW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t state, state_n;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   fall, cs_fall, cs_rise;

  logic [CW-1:0]          bit_cnt;
  logic                   is_read;
  logic [DATA_WIDTH-1:0]  tx_buf, tx_shift, rx_shift;
  logic                   last_bit;

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign cs_s    = cs_sync[SYNC_STAGES-1];
  assign mosi_s  = mosi_sync[SYNC_STAGES-1];
  assign fall    = sclk_d & ~sclk_s;
  assign cs_fall = cs_d & ~cs_s;
  assign cs_rise = ~cs_d & cs_s;

  assign last_bit  = (bit_cnt == CW'(DATA_WIDTH));
  assign tx_ready  = !(state == DATA && is_read);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '1;
      cs_sync   <= '1;
      mosi_sync <= '1;
      sclk_d    <= 1'b1;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  // Synced cs high overrides every sclk edge, so a fall coincident with cs_rise is dropped.
  always_comb begin
    state_n = state;
    if (cs_s) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (cs_fall) state_n = CMD;
        CMD:     if (fall) state_n = DATA;
        DATA:    if (fall && last_bit) state_n = DONE;
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      miso      <= 1'b1;
      miso_oe   <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rd_done   <= 1'b0;
      frame_err <= 1'b0;
      tx_buf    <= '0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      bit_cnt   <= '0;
      is_read   <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      rd_done   <= 1'b0;
      frame_err <= 1'b0;
      // A read's CMD fall copies the old tx_buf into tx_shift, so a same-cycle load is for the next frame.
      if (tx_load && tx_ready) tx_buf <= tx_data;
      if (cs_s) begin
        if (cs_rise && ((state == CMD && bit_cnt != '0) || state == DATA)) frame_err <= 1'b1;
        miso    <= 1'b1;
        miso_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: if (cs_fall) bit_cnt <= '0;
          CMD: begin
            if (fall) begin
              bit_cnt <= bit_cnt + CW'(1);
              is_read <= mosi_s;
              if (mosi_s) begin
                tx_shift <= tx_buf >> 1;
                miso     <= tx_buf[0];
                miso_oe  <= 1'b1;
              end
            end
          end
          DATA: begin
            if (fall) begin
              bit_cnt <= bit_cnt + CW'(1);
              if (is_read) begin
                if (!last_bit) begin
                  miso     <= tx_shift[0];
                  tx_shift <= tx_shift >> 1;
                end else begin
                  rd_done <= 1'b1;
                end
              end else begin
                rx_shift <= {mosi_s, rx_shift[DATA_WIDTH-1:1]};
                if (last_bit) begin
                  rx_data  <= {mosi_s, rx_shift[DATA_WIDTH-1:1]};
                  rx_valid <= 1'b1;
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: a bit-banged SPI master drives frames; a scoreboard
// matches rx_valid / rd_done / frame_err pulses against queued expectations.
module tb_spi_slave_if;

  localparam int DW    = 8;
  localparam int PHASE = 9;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sclk = 1'b1;
  logic          cs = 1'b1;
  logic          mosi = 1'b1;
  logic          miso, miso_oe, tx_ready, rx_valid, rd_done, frame_err;
  logic [DW-1:0] tx_data = '0;
  logic          tx_load = 1'b0;
  logic [DW-1:0] rx_data;
  logic [1:0]    dbg_state;

  logic [DW-1:0] rx_exp_q[$];
  logic [DW-1:0] rd_exp_q[$];
  logic          err_exp_q[$];
  logic [DW-1:0] mst_cap = '0;

  int n_checks = 0;
  int n_fail   = 0;

  spi_slave_if #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .cs(cs), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .rd_done(rd_done), .frame_err(frame_err), .dbg_state(dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic load_tx(input logic [DW-1:0] d);
    tx_data = d;
    tx_load = 1'b1;
    wait_clk(1);
    tx_load = 1'b0;
  endtask

  // Sends nbits of a frame (cmd bit then data LSB first); master captures miso before each rise.
  task automatic spi_frame(input logic cmd, input logic [DW-1:0] data, input int nbits,
                           input bit close_cs, input bit mid_load);
    cs = 1'b0;
    wait_clk(PHASE);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i == 0) ? cmd : data[i-1];
      wait_clk(PHASE);
      sclk = 1'b0;
      wait_clk(PHASE);
      if (i < DW) mst_cap[i] = miso;
      if (i == 4) begin
        check("tx_ready_mid", tx_ready, !cmd);
        check("miso_oe_mid", miso_oe, cmd);
        if (mid_load) load_tx(8'h77);
      end
      sclk = 1'b1;
    end
    if (close_cs) begin
      wait_clk(PHASE);
      cs = 1'b1;
      mosi = 1'b1;
      wait_clk(PHASE + 4);
    end
  endtask

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid) begin
        if (rx_exp_q.size() == 0) check("rx_valid_unexpected", 1, 0);
        else check("rx_data", rx_data, rx_exp_q.pop_front());
      end
      if (rd_done) begin
        if (rd_exp_q.size() == 0) check("rd_done_unexpected", 1, 0);
        else check("read_capture", mst_cap, rd_exp_q.pop_front());
      end
      if (frame_err) begin
        if (err_exp_q.size() == 0) check("frame_err_unexpected", 1, 0);
        else check("frame_err", frame_err, err_exp_q.pop_front());
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_miso"}, miso, 1);
    check({tag, "_miso_oe"}, miso_oe, 0);
    check({tag, "_tx_ready"}, tx_ready, 1);
    check({tag, "_rx_data"}, rx_data, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_rd_done"}, rd_done, 0);
    check({tag, "_frame_err"}, frame_err, 0);
  endtask

  initial begin
    wait_clk(3);
    check_reset_values("reset");
    reset_n = 1'b1;
    wait_clk(5);

    // Read with nothing loaded, then back-to-back write 0xFF and read
    rd_exp_q.push_back(8'h00);
    spi_frame(1'b1, 8'h00, DW + 1, 1, 0);
    rx_exp_q.push_back(8'hFF);
    spi_frame(1'b0, 8'hFF, DW + 1, 1, 0);
    rd_exp_q.push_back(8'h00);
    spi_frame(1'b1, 8'h00, DW + 1, 1, 0);
    check("rx_after_ff", rx_data, 8'hFF);

    // Write frame 0xA5
    rx_exp_q.push_back(8'hA5);
    spi_frame(1'b0, 8'hA5, DW + 1, 1, 0);
    check("miso_oe_after_write", miso_oe, 0);

    // Read frame returning a loaded 0x3C
    load_tx(8'h3C);
    rd_exp_q.push_back(8'h3C);
    spi_frame(1'b1, 8'h00, DW + 1, 1, 0);
    check("miso_released", miso, 1);
    check("miso_oe_released", miso_oe, 0);

    // Partial write frame: cmd plus 4 data bits of 0x5A
    err_exp_q.push_back(1'b1);
    spi_frame(1'b0, 8'h5A, 5, 1, 0);
    check("rx_data_kept", rx_data, 8'hA5);

    // Load during read DATA is dropped; IDLE load is accepted
    rd_exp_q.push_back(8'h3C);
    spi_frame(1'b1, 8'h00, DW + 1, 1, 1);
    rd_exp_q.push_back(8'h3C);
    spi_frame(1'b1, 8'h00, DW + 1, 1, 0);
    load_tx(8'h11);
    rd_exp_q.push_back(8'h11);
    spi_frame(1'b1, 8'h00, DW + 1, 1, 0);

    // Asynchronous reset at bit 5 of a read frame
    spi_frame(1'b1, 8'h00, 6, 0, 0);
    reset_n = 1'b0;
    #1;
    check_reset_values("midreset");
    wait_clk(2);
    reset_n = 1'b1;
    wait_clk(4);
    cs = 1'b1;
    mosi = 1'b1;
    wait_clk(PHASE + 4);
    rx_exp_q.push_back(8'h81);
    spi_frame(1'b0, 8'h81, DW + 1, 1, 0);
    check("rx_after_reset", rx_data, 8'h81);

    wait_clk(20);
    check("rx_queue_drained", rx_exp_q.size(), 0);
    check("rd_queue_drained", rd_exp_q.size(), 0);
    check("err_queue_drained", err_exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
